// File: rtl/od_bus_arbiter.sv
// Round-robin arbiter/sequencer for an open-drain bus: grant, hold pull-downs, release, wait out the RC rise.
// Latency: grant is registered one cycle after the IDLE sample; no backpressure, requesters hold req until granted.
module od_bus_arbiter #(
  parameter int REQUESTERS     = 4,
  parameter int WIDTH          = 8,
  parameter int SETTLE_CYCLES  = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [REQUESTERS-1:0]           req,
  input  logic [REQUESTERS-1:0]           done,
  input  logic [REQUESTERS*WIDTH-1:0]     data_in,
  output logic [REQUESTERS-1:0]           grant,
  output logic [WIDTH-1:0]                bus_pull,
  output logic                            bus_valid,
  output logic [$clog2(REQUESTERS)-1:0]   owner,
  output logic                            timeout
);

  localparam int OW     = $clog2(REQUESTERS);
  localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
  localparam int SW_RAW = $clog2(SETTLE_CYCLES + 1);
  localparam int SW     = (SW_RAW < 1) ? 1 : SW_RAW;

  typedef enum logic [1:0] {IDLE, DRIVE, RECOVER} state_t;

  state_t                  state, state_nxt;
  logic [REQUESTERS-1:0]   grant_nxt;
  logic [WIDTH-1:0]        bus_pull_nxt;
  logic                    bus_valid_nxt;
  logic [OW-1:0]           owner_nxt;
  logic                    timeout_nxt;
  logic [TW-1:0]           tenure, tenure_nxt;
  logic [SW-1:0]           settle_cnt, settle_nxt;

  logic [WIDTH-1:0]        data_arr [REQUESTERS];
  logic [OW-1:0]           win;
  logic                    own_end, at_limit, tenure_exit, forced;

  for (genvar k = 0; k < REQUESTERS; k++) begin : g_data
    assign data_arr[k] = data_in[k*WIDTH +: WIDTH];
  end

  // Scan upward from the slot after the last owner so every requester gets a turn.
  always_comb begin
    int idx;
    logic found;
    win   = owner;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= REQUESTERS; i++) begin
      idx = (int'(owner) + i) % REQUESTERS;
      if (!found && req[OW'(idx)]) begin
        win   = OW'(idx);
        found = 1'b1;
      end
    end
  end

  // A done/abort landing on the limit cycle counts as a normal end, not a forced one.
  assign own_end     = done[owner] | ~req[owner];
  assign at_limit    = (tenure == TW'(TIMEOUT_CYCLES));
  assign tenure_exit = own_end | at_limit;
  assign forced      = at_limit & ~own_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      bus_pull   <= '0;
      bus_valid  <= 1'b0;
      owner      <= OW'(REQUESTERS - 1);
      timeout    <= 1'b0;
      tenure     <= '0;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      bus_pull   <= bus_pull_nxt;
      bus_valid  <= bus_valid_nxt;
      owner      <= owner_nxt;
      timeout    <= timeout_nxt;
      tenure     <= tenure_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = DRIVE;
      DRIVE:   if (tenure_exit) state_nxt = (SETTLE_CYCLES == 0) ? IDLE : RECOVER;
      RECOVER: if (settle_cnt == SW'(SETTLE_CYCLES)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_nxt     = grant;
    bus_pull_nxt  = bus_pull;
    bus_valid_nxt = bus_valid;
    owner_nxt     = owner;
    timeout_nxt   = 1'b0;
    tenure_nxt    = tenure;
    settle_nxt    = settle_cnt;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_nxt     = REQUESTERS'(1) << win;
          owner_nxt     = win;
          bus_pull_nxt  = ~data_arr[win];
          bus_valid_nxt = 1'b0;
          tenure_nxt    = TW'(1);
        end
      end
      DRIVE: begin
        if (tenure_exit) begin
          grant_nxt     = '0;
          bus_pull_nxt  = '0;
          bus_valid_nxt = 1'b0;
          timeout_nxt   = forced;
          tenure_nxt    = '0;
          settle_nxt    = SW'(1);
        end else begin
          // Pull-down completes within one cycle, so the bus is valid from the second cycle.
          bus_valid_nxt = 1'b1;
          tenure_nxt    = tenure + TW'(1);
        end
      end
      RECOVER: begin
        settle_nxt = (settle_cnt == SW'(SETTLE_CYCLES)) ? '0 : settle_cnt + SW'(1);
      end
      default: begin
        grant_nxt     = '0;
        bus_pull_nxt  = '0;
        bus_valid_nxt = 1'b0;
      end
    endcase
  end

endmodule
